// File: rtl/register_file_if.sv
// Register file access bus: one write port, two combinational read ports, sticky error.
// Master drives addresses/data/controls; slave returns read data, valid flags and err.
interface register_file_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
);
  logic             w_en;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic [AW-1:0]    ra_addr;
  logic [AW-1:0]    rb_addr;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic             ra_valid;
  logic             rb_valid;
  logic             err_clr;
  logic             err;

  modport master (
    output w_en, w_addr, w_data, ra_addr, rb_addr, err_clr,
    input  ra_data, rb_data, ra_valid, rb_valid, err
  );

  modport slave (
    input  w_en, w_addr, w_data, ra_addr, rb_addr, err_clr,
    output ra_data, rb_data, ra_valid, rb_valid, err
  );
endinterface

// File: rtl/register_file.sv
// DEPTH x WIDTH register file, 1 write / 2 combinational reads, written-since-reset flags, sticky err.
// Latency: write visible after one edge (same cycle with BYPASS); no backpressure, always accepts.
module register_file #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter int unsigned      AW      = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               BYPASS  = 1'b1
) (
  input logic           clk,
  input logic           rst,
  register_file_if.slave bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             err_q;
  logic             w_in_range;
  logic             wr_ok;
  logic             en_unknown;
  logic             err_set;

  assign w_in_range = 32'(bus.w_addr) < DEPTH;
  assign wr_ok      = bus.w_en & w_in_range;

  // An X/Z enable can only be observed in a four-state simulator; hardware sees a plain 0.
`ifndef SYNTHESIS
  assign en_unknown = (bus.w_en !== 1'b0) && (bus.w_en !== 1'b1);
`else
  assign en_unknown = 1'b0;
`endif

  assign err_set = (bus.w_en & ~w_in_range) | en_unknown;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= RST_VAL;
      end
      valid <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[bus.w_addr]   <= bus.w_data;
        valid[bus.w_addr] <= 1'b1;
      end
      // Set has priority over clear so a fresh error is never lost.
      if (err_set) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  // Returns {valid, data}; out-of-range addresses read as zero and never bypass.
  function automatic logic [WIDTH:0] read_port(input logic [AW-1:0] addr);
    logic [WIDTH:0] r;
    r = '0;
    if (32'(addr) < DEPTH) begin
      r = {valid[addr], mem[addr]};
    end
    if (BYPASS && wr_ok && (addr == bus.w_addr)) begin
      r = {1'b1, bus.w_data};
    end
    return r;
  endfunction

  always_comb begin
    {bus.ra_valid, bus.ra_data} = read_port(bus.ra_addr);
    {bus.rb_valid, bus.rb_data} = read_port(bus.rb_addr);
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench: three register_file instances (default, BYPASS=0, DEPTH=3) share one stimulus stream.
// Expected values are hand-computed constants.
module tb_register_file;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic [1:0] w_addr;
  logic [7:0] w_data;
  logic [1:0] ra_addr;
  logic [1:0] rb_addr;
  logic       err_clr;

  int vecs = 0;
  int miss = 0;
  logic probe;
  bit   four_state;

  register_file_if #(.WIDTH(8), .AW(2)) bus0 ();
  register_file_if #(.WIDTH(8), .AW(2)) bus1 ();
  register_file_if #(.WIDTH(8), .AW(2)) bus2 ();

  assign bus0.w_en = w_en;  assign bus0.w_addr = w_addr;  assign bus0.w_data = w_data;
  assign bus0.ra_addr = ra_addr;  assign bus0.rb_addr = rb_addr;  assign bus0.err_clr = err_clr;
  assign bus1.w_en = w_en;  assign bus1.w_addr = w_addr;  assign bus1.w_data = w_data;
  assign bus1.ra_addr = ra_addr;  assign bus1.rb_addr = rb_addr;  assign bus1.err_clr = err_clr;
  assign bus2.w_en = w_en;  assign bus2.w_addr = w_addr;  assign bus2.w_data = w_data;
  assign bus2.ra_addr = ra_addr;  assign bus2.rb_addr = rb_addr;  assign bus2.err_clr = err_clr;

  register_file #(.WIDTH(8), .DEPTH(4), .AW(2), .RST_VAL(8'h00), .BYPASS(1'b1))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  register_file #(.WIDTH(8), .DEPTH(4), .AW(2), .RST_VAL(8'h00), .BYPASS(1'b0))
    u1 (.clk(clk), .rst(rst), .bus(bus1));
  register_file #(.WIDTH(8), .DEPTH(3), .AW(2), .RST_VAL(8'h00), .BYPASS(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0;
    ra_addr = '0; rb_addr = '0; err_clr = 1'b0;
    probe = 1'bx;
    four_state = $isunknown(probe);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    ra_addr = 2'd2; rb_addr = 2'd3; #1;
    check("rst d0 ra",     bus0.ra_data, 8'h00);
    check("rst d0 ra_v",   8'(bus0.ra_valid), 8'h0);
    check("rst d0 err",    8'(bus0.err), 8'h0);
    check("rst d2 oor",    bus2.rb_data, 8'h00);
    check("rst d2 oor_v",  8'(bus2.rb_valid), 8'h0);

    // 1: basic write
    w_en = 1'b1; w_addr = 2'd2; w_data = 8'hA5;
    tick;
    w_en = 1'b0;
    ra_addr = 2'd2; rb_addr = 2'd1; #1;
    check("wr ra",    bus0.ra_data, 8'hA5);
    check("wr ra_v",  8'(bus0.ra_valid), 8'h1);
    check("wr rb",    bus0.rb_data, 8'h00);
    check("wr rb_v",  8'(bus0.rb_valid), 8'h0);
    check("wr err",   8'(bus0.err), 8'h0);

    // 2: bypass vs no bypass, same cycle
    w_en = 1'b1; w_addr = 2'd3; w_data = 8'h3C; ra_addr = 2'd3; rb_addr = 2'd3; #1;
    check("byp d0 ra",   bus0.ra_data, 8'h3C);
    check("byp d0 rb",   bus0.rb_data, 8'h3C);
    check("byp d0 ra_v", 8'(bus0.ra_valid), 8'h1);
    check("byp d0 rb_v", 8'(bus0.rb_valid), 8'h1);
    check("nbyp d1 ra",   bus1.ra_data, 8'h00);
    check("nbyp d1 rb",   bus1.rb_data, 8'h00);
    check("nbyp d1 ra_v", 8'(bus1.ra_valid), 8'h0);
    check("nbyp d1 rb_v", 8'(bus1.rb_valid), 8'h0);
    check("oor d2 nobyp", bus2.ra_data, 8'h00);
    check("oor d2 nobyp_v", 8'(bus2.ra_valid), 8'h0);
    tick;
    w_en = 1'b0; #1;
    check("nbyp d1 post",   bus1.ra_data, 8'h3C);
    check("nbyp d1 post_v", 8'(bus1.ra_valid), 8'h1);
    check("d2 err illegal", 8'(bus2.err), 8'h1);
    check("d0 err legal",   8'(bus0.err), 8'h0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("d2 err clr", 8'(bus2.err), 8'h0);

    // 3: illegal write on DEPTH=3, sticky err
    w_en = 1'b1; w_addr = 2'd3; w_data = 8'hFF;
    tick;
    w_en = 1'b0;
    check("ill err", 8'(bus2.err), 8'h1);
    for (int a = 0; a < 3; a++) begin
      ra_addr = 2'(a); #1;
      check($sformatf("ill d2 r%0d", a), bus2.ra_data, (a == 2) ? 8'hA5 : 8'h00);
    end
    ra_addr = 2'd3; #1;
    check("d0 legal r3", bus0.ra_data, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      tick;
      check($sformatf("sticky %0d", k), 8'(bus2.err), 8'h1);
    end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("clr err", 8'(bus2.err), 8'h0);

    // 4a: set wins over clear
    err_clr = 1'b1; w_en = 1'b1; w_addr = 2'd3; w_data = 8'h5A;
    tick;
    err_clr = 1'b0; w_en = 1'b0;
    check("set wins", 8'(bus2.err), 8'h1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("set wins clr", 8'(bus2.err), 8'h0);

    // 4b: unknown write enable (only meaningful on a four-state simulator)
    if (four_state) begin
      w_en = 1'bx; w_addr = 2'd2; w_data = 8'hEE;
      tick;
      w_en = 1'b0;
      ra_addr = 2'd2; #1;
      check("x err",  8'(bus0.err), 8'h1);
      check("x data", bus0.ra_data, 8'hA5);
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
    end else begin
      $display("note: two-state simulator, unknown-enable vector skipped");
    end

    // 5: asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; w_addr = 2'(i); w_data = 8'h77;
      tick;
    end
    w_en = 1'b0;
    ra_addr = 2'd1; rb_addr = 2'd2; #1;
    check("pre rst ra", bus0.ra_data, 8'h77);
    check("pre rst d2 err", 8'(bus2.err), 8'h1);
    #3 rst = 1'b1;
    #1;
    check("arst ra",   bus0.ra_data, 8'h00);
    check("arst rb",   bus0.rb_data, 8'h00);
    check("arst ra_v", 8'(bus0.ra_valid), 8'h0);
    check("arst d2 err", 8'(bus2.err), 8'h0);
    w_en = 1'b1; w_addr = 2'd0; w_data = 8'h99; ra_addr = 2'd0; rb_addr = 2'd1;
    tick;
    check("rst blocks wr", bus1.ra_data, 8'h00);
    rst = 1'b0;
    tick;
    w_en = 1'b0; #1;
    check("post rel wr",   bus0.ra_data, 8'h99);
    check("post rel wr_v", 8'(bus0.ra_valid), 8'h1);
    check("post rel r1",   bus0.rb_data, 8'h00);
    check("post rel r1_v", 8'(bus0.rb_valid), 8'h0);

    // 6: sweep every address pair
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; w_addr = 2'(i); w_data = 8'(16 + i);
      tick;
    end
    w_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        ra_addr = 2'(a); rb_addr = 2'(b); #1;
        check($sformatf("sweep a%0d", a), bus0.ra_data, 8'(16 + a));
        check($sformatf("sweep b%0d", b), bus0.rb_data, 8'(16 + b));
      end
      check($sformatf("sweep v%0d", a), 8'(bus0.ra_valid), 8'h1);
      check($sformatf("d2 r%0d", a),   bus2.ra_data, (a < 3) ? 8'(16 + a) : 8'h00);
      check($sformatf("d2 v%0d", a),   8'(bus2.ra_valid), (a < 3) ? 8'h1 : 8'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
